block_rx_ctrl: RTL and testbench

Controller that sequences the UART receive byte stream into 64-bit blocks for the downstream 64-bit datapath. It sits between the UART receiver (byte plus done strobe) and the block consumer. It has these functions:
- edge-qualifies byte arrivals
- packs eight bytes little-endian into an assembly register
- hands completed blocks over through a valid/ready output register
- discards stalled partial frames after a timeout
- flags bytes lost to back-pressure.

---
 rtl/block_rx_ctrl_if.sv | 22 ++
 rtl/block_rx_ctrl.sv | 80 ++++++++
 tb/tb_block_rx_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/block_rx_ctrl_if.sv
// block_rx_ctrl_if: byte-in / block-out bus of the UART block receive controller.
interface block_rx_ctrl_if;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        blk_ready;
   logic        clr_err;
   logic [63:0] blk_data;
   logic        blk_valid;
   logic [3:0]  byte_cnt;
   logic        busy;
   logic        timeout;
   logic        overflow;
   logic        err_sticky;
   modport master (
      output rx_data, rx_done, blk_ready, clr_err,
      input  blk_data, blk_valid, byte_cnt, busy, timeout, overflow, err_sticky
   );
   modport slave (
      input  rx_data, rx_done, blk_ready, clr_err,
      output blk_data, blk_valid, byte_cnt, busy, timeout, overflow, err_sticky
   );
endinterface

// File: rtl/block_rx_ctrl.sv
// block_rx_ctrl: packs UART bytes little-endian into 64-bit blocks behind a valid/ready output register.
module block_rx_ctrl #(
   parameter int TIMEOUT = 50000,
   parameter int TO_W    = 16
) (
   input logic            clk,
   input logic            rst,
   block_rx_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   state_t          state, state_n;
   logic            rx_done_d, ev, out_free, store, load_out, to_hit, ovf;
   logic [63:0]     asm_q, data;
   logic            valid, err;
   logic [3:0]      cnt;
   logic [TO_W-1:0] idle;
   assign ev             = bus.rx_done & ~rx_done_d;
   assign out_free       = ~valid | bus.blk_ready;
   assign bus.blk_data   = data;
   assign bus.blk_valid  = valid;
   assign bus.byte_cnt   = cnt;
   assign bus.busy       = state != IDLE;
   assign bus.timeout    = to_hit;
   assign bus.overflow   = ovf;
   assign bus.err_sticky = err;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end
   always_comb begin
      state_n  = state;
      store    = 1'b0;
      load_out = 1'b0;
      to_hit   = 1'b0;
      ovf      = 1'b0;
      case (state)
         IDLE: begin
            store   = ev;
            state_n = ev ? COLLECT : IDLE;
         end
         COLLECT: begin
            store = ev;
            if (ev) state_n = (cnt == 4'd7) ? FULL : COLLECT;
            else if (TIMEOUT != 0 && idle == TO_LAST) begin
               to_hit  = 1'b1;
               state_n = IDLE;
            end
         end
         FULL: begin
            // a byte arriving as the block leaves becomes byte 0 of the next frame
            load_out = out_free;
            store    = out_free & ev;
            ovf      = ~out_free & ev;
            state_n  = out_free ? (ev ? COLLECT : IDLE) : FULL;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (store) asm_q[{cnt[2:0], 3'b000} +: 8] <= bus.rx_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_done_d <= 1'b0;
         cnt       <= 4'd0;
         idle      <= '0;
         data      <= 64'd0;
         valid     <= 1'b0;
         err       <= 1'b0;
      end else begin
         rx_done_d <= bus.rx_done;
         cnt       <= store ? (load_out ? 4'd1 : cnt + 4'd1) : (load_out | to_hit) ? 4'd0 : cnt;
         idle      <= (store | to_hit | state != COLLECT) ? '0 : (idle == TO_LAST) ? idle : idle + TO_W'(1);
         if (load_out) data <= asm_q;
         valid     <= load_out | (valid & ~bus.blk_ready);
         err       <= to_hit | ovf | (err & ~bus.clr_err);
      end
   end
endmodule

// File: tb/tb_block_rx_ctrl.sv
// tb_block_rx_ctrl: directed and random byte streams scored against a queue-based frame model.
module tb_block_rx_ctrl;
   localparam int TO = 10;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   block_rx_ctrl_if bus();
   block_rx_ctrl #(.TIMEOUT(TO), .TO_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   int total = 0;
   int passed = 0;
   logic rnd_rdy = 1'b0;
   logic done = 1'b0;
   logic end_chk = 1'b0;
   // model: bytes of the open frame, completed blocks awaiting handover, and what the outputs should show
   logic [7:0]  part[$];
   logic [63:0] sb[$];
   logic        held = 1'b0, outv = 1'b0, err = 1'b0, prev = 1'b0;
   logic [63:0] hold_data = 64'd0, out_data = 64'd0;
   int          age = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
   endtask
   always @(negedge clk) begin
      logic ev, to, ov;
      logic [63:0] d;
      chk("byte_cnt", 64'(bus.byte_cnt), held ? 64'd8 : 64'(part.size()));
      chk("blk_valid", 64'(bus.blk_valid), 64'(outv));
      chk("blk_data", bus.blk_data, out_data);
      chk("busy", 64'(bus.busy), 64'(held || part.size() != 0));
      chk("err_sticky", 64'(bus.err_sticky), 64'(err));
      if (rst) begin
         part.delete();
         sb.delete();
         held = 1'b0;
         outv = 1'b0;
         out_data = 64'd0;
         err = 1'b0;
         age = 0;
         prev = 1'b0;
      end else begin
         ev = bus.rx_done & ~prev;
         to = 1'b0;
         ov = 1'b0;
         if (outv && bus.blk_ready) begin
            if (sb.size() == 0) begin
               total++;
               $display("FAIL handover: got %0h, want no block at %0t", bus.blk_data, $time);
            end else chk("handover", bus.blk_data, sb.pop_front());
         end
         if (held) begin
            if (!outv || bus.blk_ready) begin
               outv = 1'b1;
               out_data = hold_data;
               held = 1'b0;
               if (ev) begin
                  part.push_back(bus.rx_data);
                  age = 0;
               end
            end else ov = ev;
         end else begin
            if (outv && bus.blk_ready) outv = 1'b0;
            if (ev) begin
               part.push_back(bus.rx_data);
               age = 0;
               if (part.size() == 8) begin
                  for (int k = 0; k < 8; k++) d[8*k +: 8] = part[k];
                  hold_data = d;
                  sb.push_back(d);
                  part.delete();
                  held = 1'b1;
               end
            end else if (part.size() != 0) begin
               age++;
               if (age == TO) begin
                  to = 1'b1;
                  part.delete();
               end
            end
         end
         chk("timeout", 64'(bus.timeout), 64'(to));
         chk("overflow", 64'(bus.overflow), 64'(ov));
         err = (to | ov) ? 1'b1 : bus.clr_err ? 1'b0 : err;
         prev = bus.rx_done;
      end
      if (done && !end_chk) begin
         chk("sb_drained", 64'(sb.size()), 64'd0);
         end_chk = 1'b1;
      end
   end
   task automatic tick();
      @(posedge clk);
      #2;
      if (rnd_rdy) begin
         bus.blk_ready = 1'($urandom_range(0, 1));
         bus.clr_err = ($urandom_range(0, 24) == 0);
      end
   endtask
   task automatic send(input logic [7:0] b, input int hi, input int lo);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      repeat (hi) tick();
      bus.rx_done = 1'b0;
      repeat (lo) tick();
   endtask
   initial begin
      bus.rx_data = 8'd0;
      bus.rx_done = 1'b0;
      bus.blk_ready = 1'b1;
      bus.clr_err = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) send(8'(i), 1, 1);
      repeat (4) tick();
      send(8'h33, 20, 15);
      for (int i = 0; i < 3; i++) send(8'h21 + 8'(i), 1, 1);
      repeat (15) tick();
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1, 1);
      repeat (4) tick();
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      bus.blk_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 1, 1);
      for (int i = 0; i < 8; i++) send(8'hB0 + 8'(i), 1, 1);
      repeat (3) tick();
      bus.rx_data = 8'hC0;
      bus.rx_done = 1'b1;
      bus.clr_err = 1'b1;
      tick();
      bus.rx_done = 1'b0;
      bus.clr_err = 1'b0;
      repeat (2) tick();
      bus.rx_data = 8'h55;
      bus.rx_done = 1'b1;
      bus.blk_ready = 1'b1;
      tick();
      bus.rx_done = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) send(8'h56 + 8'(i), 1, 1);
      repeat (4) tick();
      bus.blk_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(8'hE0 + 8'(i), 1, 1);
      for (int i = 0; i < 5; i++) send(8'hF0 + 8'(i), 1, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.blk_ready = 1'b1;
      repeat (3) tick();
      rnd_rdy = 1'b1;
      repeat (250) send(8'($urandom), $urandom_range(1, 3),
                        ($urandom_range(0, 9) == 0) ? $urandom_range(9, 14) : $urandom_range(1, 3));
      rnd_rdy = 1'b0;
      bus.blk_ready = 1'b1;
      bus.clr_err = 1'b0;
      repeat (30) tick();
      done = 1'b1;
      repeat (2) tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
